mips_mc_control: RTL

Multicycle main controller for the 8-bit MIPS datapath. A Moore FSM decodes the instruction opcode and sequences the datapath:
- byte-wide 4-cycle instruction fetch, then decode, execute, memory access and writeback.
- drives the 2-bit aluop consumed by the ALU function decoder.
- waits on a memory-ready handshake for every memory access.

---
 rtl/mips_mc_control.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mips_mc_control.sv
// Multicycle main controller for the 8-bit MIPS datapath.
// A Moore FSM sequences a byte-wide 4-cycle fetch, then decode, execute, memory access and
// writeback. Memory states wait on the memready handshake when MEM_WAIT_EN is set.
//
// Ports:
//   clk, reset (async, active-low)    clock and reset
//   op, zero, memready                opcode (IR[31:26]), ALU zero flag, memory ready
//   memread, memwrite, iord           memory strobes and address select
//   irwrite                           one-hot IR byte-lane enable
//   alusrca, alusrcb, aluop           ALU operand selects and operation class
//   pcsource, pcen                    PC source select and load enable
//   regwrite, regdst, memtoreg        register file write controls
//   illegal                           unsupported opcode seen
//   state_o                           current state (debug)
module mips_mc_control #(
  parameter bit MEM_WAIT_EN    = 1'b1,
  parameter bit ILLEGAL_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       memready,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic [3:0] irwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic       pcen,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       illegal,
  output logic [3:0] state_o
);

  localparam logic [3:0] FETCH1  = 4'd0;
  localparam logic [3:0] FETCH2  = 4'd1;
  localparam logic [3:0] FETCH3  = 4'd2;
  localparam logic [3:0] FETCH4  = 4'd3;
  localparam logic [3:0] DECODE  = 4'd4;
  localparam logic [3:0] MEMADR  = 4'd5;
  localparam logic [3:0] LBRD    = 4'd6;
  localparam logic [3:0] LBWR    = 4'd7;
  localparam logic [3:0] SBWR    = 4'd8;
  localparam logic [3:0] RTYPEEX = 4'd9;
  localparam logic [3:0] RTYPEWR = 4'd10;
  localparam logic [3:0] BEQEX   = 4'd11;
  localparam logic [3:0] JEX     = 4'd12;
  localparam logic [3:0] ADDIEX  = 4'd13;
  localparam logic [3:0] ADDIWR  = 4'd14;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [3:0] state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       rdy;
  logic       pcwrite, pcwritecond;

  // Gating with reset makes the in-reset outputs equal FETCH1 with rdy=0 (no IR/PC load).
  assign rdy = reset & (MEM_WAIT_EN ? memready : 1'b1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH1;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      FETCH1: begin
        if (rdy) begin
          state_d = FETCH2;
          if (!ILLEGAL_STICKY) illegal_d = 1'b0;
        end
      end
      FETCH2, FETCH3: if (rdy) state_d = state_q + 4'd1;
      FETCH4:         if (rdy) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LB, OP_SB: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_J:         state_d = JEX;
          OP_ADDI:      state_d = ADDIEX;
          default: begin
            state_d   = FETCH1;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEMADR:  state_d = (op == OP_SB) ? SBWR : LBRD;
      LBRD:    if (rdy) state_d = LBWR;
      SBWR:    if (rdy) state_d = FETCH1;
      RTYPEEX: state_d = RTYPEWR;
      ADDIEX:  state_d = ADDIWR;
      default: state_d = FETCH1;  // LBWR, RTYPEWR, BEQEX, JEX, ADDIWR and encoding 15
    endcase
  end

  always_comb begin
    memread     = 1'b0;
    memwrite    = 1'b0;
    iord        = 1'b0;
    irwrite     = 4'b0000;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    pcsource    = 2'b00;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    regwrite    = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    case (state_q)
      FETCH1, FETCH2, FETCH3, FETCH4: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        // Low two state bits select the byte lane being fetched.
        irwrite = 4'(rdy) << state_q[1:0];
        pcwrite = rdy;
      end
      DECODE: alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      LBRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      LBWR: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      SBWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      RTYPEWR: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      BEQEX: begin
        alusrca     = 1'b1;
        aluop       = 2'b01;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
      end
      JEX: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
      end
      ADDIWR: regwrite = 1'b1;
      default: ;
    endcase
  end

  assign pcen    = pcwrite | (pcwritecond & zero);
  assign illegal = illegal_q;
  assign state_o = state_q;

endmodule
